// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter : 3-cycle SPRAM sequencer sharing video RAM between video
//                fetch (fixed priority) and host. Optional: VRAM_STARVE_GUARD_EN
// Revision     : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } fsm_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_VID  = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("vram_arbiter: MAX_WAIT must be at least 1");
  end

  fsm_t          cur_st, nxt_st;
  logic [1:0]    state_d;
  logic          cs_d, we_d, vack_d, hack_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d, vrd_d, hrd_d;
  logic          starve_hit;
  logic          grant_host;

  // Host wins only when video is absent, or when the starvation guard fires.
  assign grant_host = host_req && (!vid_req || starve_hit);

`ifdef VRAM_STARVE_GUARD_EN
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] starve_cnt, starve_cnt_d;

  assign starve_hit = (starve_cnt == CW'(MAX_WAIT));

  always_comb begin
    starve_cnt_d = starve_cnt;
    if (cur_st == ST_IDLE && host_req) begin
      if (grant_host) begin
        starve_cnt_d = '0;
      end else if (vid_req && !starve_hit) begin
        starve_cnt_d = starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    nxt_st  = cur_st;
    state_d = state;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    vack_d  = 1'b0;
    hack_d  = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    vrd_d   = vid_rdata;
    hrd_d   = host_rdata;
    unique case (cur_st)
      ST_IDLE: begin
        state_d = OWN_NONE;
        if (grant_host) begin
          nxt_st  = ST_ACCESS;
          state_d = OWN_HOST;
          cs_d    = 1'b1;
          we_d    = host_we;
          addr_d  = host_addr;
          wdata_d = host_wdata;
        end else if (vid_req) begin
          nxt_st  = ST_ACCESS;
          state_d = OWN_VID;
          cs_d    = 1'b1;
          addr_d  = vid_addr;
        end
      end
      ST_ACCESS: begin
        // SRAM read data is sampled on the edge that closes the access cycle.
        nxt_st = ST_RESP;
        if (state == OWN_VID) begin
          vack_d = 1'b1;
          vrd_d  = mem_rdata;
        end else begin
          hack_d = 1'b1;
          if (!mem_we) begin
            hrd_d = mem_rdata;
          end
        end
      end
      ST_RESP: begin
        nxt_st  = ST_IDLE;
        state_d = OWN_NONE;
      end
      default: begin
        nxt_st  = ST_IDLE;
        state_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st     <= ST_IDLE;
      state      <= OWN_NONE;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vid_ack    <= 1'b0;
      host_ack   <= 1'b0;
      vid_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      cur_st     <= nxt_st;
      state      <= state_d;
      mem_cs     <= cs_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      vid_ack    <= vack_d;
      host_ack   <= hack_d;
      vid_rdata  <= vrd_d;
      host_rdata <= hrd_d;
    end
  end

endmodule
`default_nettype wire
